// File: rtl/alarm_qsys_onchip_mem_arbiter_if.sv
// One Avalon-MM agent link between an interconnect master and the arbiter.
// The master modport drives the command; the slave modport returns stall and read data.
interface alarm_qsys_onchip_mem_arbiter_if;
    logic [11:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/alarm_qsys_onchip_mem_arbiter.sv
// Round-robin two-master arbiter in front of the single-port on-chip RAM,
// with an optional zero-fill pass after reset and out-of-range access trapping.
module alarm_qsys_onchip_mem_arbiter #(
    parameter int          DEPTH          = 3072,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    alarm_qsys_onchip_mem_arbiter_if.slave       m0,
    alarm_qsys_onchip_mem_arbiter_if.slave       m1,
    output logic [11:0]                          mem_address,
    output logic [3:0]                           mem_byteenable,
    output logic [31:0]                          mem_writedata,
    output logic                                 mem_chipselect,
    output logic                                 mem_write,
    output logic                                 mem_clken,
    input  logic [31:0]                          mem_readdata,
    output logic                                 busy,
    output logic                                 err_addr
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [12:0] DEPTH_W   = 13'(DEPTH);
    localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [11:0]       clr_addr_q, clr_addr_d;
    logic [11:0]       addr_hold_q;
    logic              last_grant_q;
    logic              rd_valid_q, rd_owner_q, rd_err_q;
    logic [1:0][31:0]  rdata_q;

    logic [1:0]        req, wr_req, oor, wait_req, rdv;
    logic [1:0][11:0]  addr;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  wdata;
    logic              run, grant_vld, win;
    logic [31:0]       rd_data;

    assign req    = {m1.read | m1.write, m0.read | m0.write};
    assign wr_req = {m1.write, m0.write};
    assign addr   = {m1.address, m0.address};
    assign be     = {m1.byteenable, m0.byteenable};
    assign wdata  = {m1.writedata, m0.writedata};
    assign oor[0] = {1'b0, m0.address} >= DEPTH_W;
    assign oor[1] = {1'b0, m1.address} >= DEPTH_W;

    // Reset gates everything combinationally so stalls appear the moment reset_n drops.
    assign run       = reset_n && (state_q == RUN);
    assign win       = (req == 2'b11) ? ~last_grant_q : req[1];
    assign grant_vld = run && (|req);

    assign wait_req[0] = !run || (req[0] && win);
    assign wait_req[1] = !run || (req[1] && !win);

    assign busy      = !reset_n || (state_q == CLEAR);
    assign err_addr  = grant_vld && oor[win];
    assign mem_clken = reset_n;

    always_comb begin
        state_d        = state_q;
        clr_addr_d     = clr_addr_q;
        mem_address    = addr_hold_q;
        mem_byteenable = be[win];
        mem_writedata  = wdata[win];
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        case (state_q)
            CLEAR: begin
                if (reset_n) begin
                    mem_address    = clr_addr_q;
                    mem_byteenable = 4'hF;
                    mem_writedata  = 32'h0;
                    mem_chipselect = 1'b1;
                    mem_write      = 1'b1;
                    clr_addr_d     = clr_addr_q + 12'd1;
                    if (clr_addr_q == LAST_ADDR) state_d = RUN;
                end
            end
            RUN: begin
                if (grant_vld) begin
                    mem_address    = addr[win];
                    mem_chipselect = !oor[win];
                    mem_write      = wr_req[win] && !oor[win];
                end
            end
            default: state_d = RUN;
        endcase
    end

    // RAM q is unregistered and arrives one cycle after the read was issued.
    assign rd_data = rd_err_q ? ERR_RDATA : mem_readdata;
    assign rdv[0]  = rd_valid_q && !rd_owner_q;
    assign rdv[1]  = rd_valid_q && rd_owner_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr_q   <= '0;
            addr_hold_q  <= '0;
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            addr_hold_q <= mem_address;
            rd_valid_q  <= grant_vld && !wr_req[win];
            if (grant_vld) begin
                last_grant_q <= win;
                rd_owner_q   <= win;
                rd_err_q     <= oor[win];
            end
            if (rd_valid_q) rdata_q[rd_owner_q] <= rd_data;
        end
    end

    assign m0.waitrequest   = wait_req[0];
    assign m1.waitrequest   = wait_req[1];
    assign m0.readdatavalid = rdv[0];
    assign m1.readdatavalid = rdv[1];
    assign m0.readdata      = rdv[0] ? rd_data : rdata_q[0];
    assign m1.readdata      = rdv[1] ? rd_data : rdata_q[1];
endmodule

// File: tb/tb_alarm_qsys_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter: RAM model plus a reference memory scoreboard
// on one cleared instance, and a second instance without the zero-fill pass.
module tb_alarm_qsys_onchip_mem_arbiter;
    localparam int          DEPTH = 3072;
    localparam logic [31:0] ERR   = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst_n, rst_b;
    always #5 clk = ~clk;

    alarm_qsys_onchip_mem_arbiter_if a0(), a1(), b0(), b1();

    logic [11:0] mem_address, b_mem_address;
    logic [3:0]  mem_byteenable, b_mem_byteenable;
    logic [31:0] mem_writedata, b_mem_writedata, mem_readdata, b_mem_readdata;
    logic        mem_chipselect, mem_write, mem_clken, busy, err_addr;
    logic        b_mem_chipselect, b_mem_write, b_mem_clken, b_busy, b_err_addr;

    alarm_qsys_onchip_mem_arbiter #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset_n(rst_n), .m0(a0), .m1(a1),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .busy(busy), .err_addr(err_addr)
    );

    alarm_qsys_onchip_mem_arbiter #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0), .ERR_RDATA(ERR)) dut_nc (
        .clk(clk), .reset_n(rst_b), .m0(b0), .m1(b1),
        .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
        .mem_writedata(b_mem_writedata), .mem_chipselect(b_mem_chipselect),
        .mem_write(b_mem_write), .mem_clken(b_mem_clken), .mem_readdata(b_mem_readdata),
        .busy(b_busy), .err_addr(b_err_addr)
    );
    assign b_mem_readdata = 32'h0;

    // RAM model: registered address, pre-filled with a non-zero pattern.
    logic [31:0] ram [0:4095];
    initial for (int i = 0; i < 4096; i++) ram[i] = 32'hA500_0000 | i;
    always @(posedge clk)
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end

    int n_vec = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t        sb [2][$];
    logic [31:0] ref_mem [0:4095];
    initial for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;

    task automatic mon(input int m, input logic rd, input logic wr, input logic wreq,
                       input logic rdv, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] rdata);
        exp_t e;
        if (rdv) begin
            chk($sformatf("m%0d_rdv_pending", m), sb[m].size() != 0, 1'b1);
            if (sb[m].size() != 0) begin
                e = sb[m].pop_front();
                chk($sformatf("m%0d_rdata", m), rdata, e.data);
                chk($sformatf("m%0d_latency", m), cyc - e.cyc, 1);
            end
        end
        if ((rd || wr) && !wreq) begin
            if (wr) begin
                if (a < DEPTH)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                e.data = (a >= DEPTH) ? ERR : ref_mem[a];
                e.cyc  = cyc;
                sb[m].push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb[0].delete();
            sb[1].delete();
        end else if (!busy) begin
            mon(0, a0.read, a0.write, a0.waitrequest, a0.readdatavalid, a0.address,
                a0.writedata, a0.byteenable, a0.readdata);
            mon(1, a1.read, a1.write, a1.waitrequest, a1.readdatavalid, a1.address,
                a1.writedata, a1.byteenable, a1.readdata);
        end
    end

    task automatic drive(input bit m, input logic rd, input logic wr, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (!m) begin
            a0.read = rd; a0.write = wr; a0.address = a; a0.writedata = d; a0.byteenable = be;
        end else begin
            a1.read = rd; a1.write = wr; a1.address = a; a1.writedata = d; a1.byteenable = be;
        end
    endtask

    task automatic acc(input bit m, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        @(posedge clk); #1;
        drive(m, !wr, wr, a, d, be);
        @(negedge clk);
        while ((m ? a1.waitrequest : a0.waitrequest) && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("accept_in_time", n < 20, 1'b1);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, a, d, be);
    endtask

    task automatic clear_check();
        int cnt = 0, bad = 0;
        @(negedge clk);
        while (busy && cnt < 5000) begin
            if (!(mem_write && mem_chipselect && mem_address == cnt[11:0] &&
                  mem_writedata == 32'h0 && mem_byteenable == 4'hF)) bad++;
            cnt++;
            @(negedge clk);
        end
        chk("clear_cycles", cnt, DEPTH);
        chk("clear_bad_writes", bad, 0);
        chk("run_busy_low", busy, 1'b0);
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        b0.read = 1'b0; b0.write = 1'b1; b0.address = 12'h0AA; b0.writedata = 32'h1; b0.byteenable = 4'hF;
        b1.read = 1'b0; b1.write = 1'b1; b1.address = 12'h0BB; b1.writedata = 32'h2; b1.byteenable = 4'hF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_wait", a0.waitrequest, 1'b1);
        chk("rst_m1_wait", a1.waitrequest, 1'b1);
        chk("rst_m0_rdv", a0.readdatavalid, 1'b0);
        chk("rst_m0_rdata", a0.readdata, 32'h0);
        chk("rst_cs", mem_chipselect, 1'b0);
        chk("rst_write", mem_write, 1'b0);
        chk("rst_clken", mem_clken, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_err", err_addr, 1'b0);
        chk("nc_rst_busy", b_busy, 1'b1);
        chk("nc_rst_wait", b0.waitrequest, 1'b1);

        @(posedge clk); #1 rst_n = 1'b1;
        clear_check();

        acc(0, 1'b0, 12'h005, 32'h0, 4'h0);
        repeat (3) @(posedge clk);

        acc(0, 1'b1, 12'h010, 32'hCAFE_F00D, 4'b0011);
        acc(1, 1'b0, 12'h010, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("m1_be_merge", a1.readdata, 32'h0000_F00D);

        acc(0, 1'b1, 12'h001, 32'h1111_1111, 4'hF);
        acc(1, 1'b1, 12'h002, 32'h2222_2222, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("alt%0d_m0_wait", i), a0.waitrequest, i % 2);
            chk($sformatf("alt%0d_m1_wait", i), a1.waitrequest, (i + 1) % 2);
            chk($sformatf("alt%0d_addr", i), mem_address, (i % 2) ? 12'h002 : 12'h001);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);

        #1 drive(1, 1'b1, 1'b0, 12'hC00, 32'h0, 4'h0);
        @(negedge clk);
        chk("oor_wait", a1.waitrequest, 1'b0);
        chk("oor_cs", mem_chipselect, 1'b0);
        chk("oor_err", err_addr, 1'b1);
        @(posedge clk); #1 drive(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("oor_err_pulse", err_addr, 1'b0);
        chk("oor_rdv", a1.readdatavalid, 1'b1);
        chk("oor_rdata", a1.readdata, ERR);
        repeat (2) @(posedge clk);

        #1 drive(0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
        @(negedge clk);
        chk("mid_accept", a0.waitrequest, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_m0_wait", a0.waitrequest, 1'b1);
        chk("mid_m1_wait", a1.waitrequest, 1'b1);
        chk("mid_busy", busy, 1'b1);
        @(negedge clk);
        chk("mid_no_rdv", a0.readdatavalid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_check();
        acc(0, 1'b0, 12'h010, 32'h0, 4'h0);
        repeat (3) @(posedge clk);

        @(posedge clk); #1 rst_b = 1'b1;
        @(negedge clk);
        chk("nc_busy", b_busy, 1'b0);
        chk("nc_m0_wait", b0.waitrequest, 1'b0);
        chk("nc_m1_wait", b1.waitrequest, 1'b1);
        chk("nc_first_write", b_mem_write, 1'b1);
        chk("nc_first_addr", b_mem_address, 12'h0AA);
        @(posedge clk); #1 b0.write = 1'b0;
        @(negedge clk);
        chk("nc_m1_wait2", b1.waitrequest, 1'b0);
        chk("nc_second_addr", b_mem_address, 12'h0BB);
        chk("nc_second_write", b_mem_write, 1'b1);
        @(posedge clk); #1 b1.write = 1'b0;

        repeat (2) @(negedge clk);
        chk("m0_sb_drained", sb[0].size(), 0);
        chk("m1_sb_drained", sb[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alarm_qsys_onchip_mem_arbiter.md
Name: alarm_qsys_onchip_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter for the 3072 x 32-bit single-port on-chip RAM (12-bit word address, 4 byte enables, 1-cycle read latency, unregistered q).
- Shares the RAM between master 0 (Nios data master) and master 1 (alarm/display scanner) with round-robin priority.
- Optionally zero-fills the RAM after reset before granting any master.
- Sits between the interconnect and the RAM's s1 port and drives its chipselect/write/clken.

Parameters:
DEPTH, 3072, number of valid words; addresses >= DEPTH are out of range
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset release; 0 = go straight to RUN
ERR_RDATA, 32'h0000_0000, read data returned for out-of-range reads

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
m0_address  in  12  master 0 word address
m0_read / m0_write  in  1 each  master 0 command strobes
m0_byteenable  in  4  master 0 byte lanes
m0_writedata  in  32  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  32  master 0 read data
m0_readdatavalid  out  1  master 0 read data strobe
m1_*  (same seven ports as m0_*)  master 1
mem_address  out  12  to RAM address
mem_byteenable  out  4  to RAM byteenable
mem_writedata  out  32  to RAM writedata
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_clken  out  1  to RAM clken (tied 1 outside reset)
mem_readdata  in  32  from RAM readdata
busy  out  1  high while reset or clear sequence active
err_addr  out  1  one-cycle pulse on any accepted out-of-range access

Behaviour:
- Reset (reset_n low, async):
  - state=CLEAR if CLEAR_ON_RESET else RUN; clr_addr=0; last_grant=1, so m0 wins the first conflict.
  - Outputs: m*_waitrequest=1, m*_readdatavalid=0, m*_readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, busy=1, err_addr=0.
- Reset asserted mid-operation: any in-flight read is dropped with no readdatavalid; the clear sequence restarts from word 0.
- CLEAR state:
  - Each cycle drives mem_address=clr_addr, mem_writedata=0, byteenable=4'hF, chipselect=1, write=1; clr_addr increments.
  - After writing word DEPTH-1, next state is RUN (DEPTH cycles total).
  - busy=1 and both waitrequests=1 throughout; master commands are ignored (held by Avalon rules).
- RUN state (busy=0, mem_clken=1):
  - A master requests when read|write is high. Write takes priority if both are set.
  - Grant is combinational in the same cycle:
    - Only one requester: it wins.
    - Both request: the master not equal to last_grant wins.
    - last_grant updates at the clock edge to the winner.
  - Winner sees waitrequest=0 and its command is forwarded to mem_* in that cycle. Loser sees waitrequest=1. A non-requesting master also sees waitrequest=0 (don't-care).
  - Throughput is one access per cycle; back-to-back conflicts alternate m0, m1, m0, ...
  - Write: mem_chipselect=1, mem_write=1, byteenable/writedata passed through. No response phase.
  - Read: mem_chipselect=1, mem_write=0. Registers rd_valid=1 and rd_owner=winner. Next cycle: owner's readdatavalid=1 and readdata=mem_readdata (fixed latency 1). The other master's readdata is held at its last value.
  - Out-of-range (address >= DEPTH):
    - Accepted (waitrequest=0); mem_chipselect=0, so the RAM is not touched.
    - err_addr pulses in the accept cycle.
    - For a read, readdatavalid still fires next cycle with ERR_RDATA.
  - Idle cycle: mem_chipselect=0, mem_write=0, mem_address holds its last value.
- Pipelining: a new read may be accepted in the same cycle that the previous read's readdatavalid fires. Ordering per master is preserved.

Test Plan:
- CLEAR_ON_RESET=1: release reset_n -> busy=1 and mem_write=1 for exactly 3072 cycles at addresses 0..3071 with data 0; busy=0 on cycle 3073; m0 read of 0x005 -> readdata 0, readdatavalid exactly 1 cycle after accept.
- m0 write 0x010=32'hCAFEF00D with byteenable 4'b0011, then m1 read 0x010 (after prior clear) -> m1_readdata=32'h0000F00D, m1_readdatavalid 1 cycle after grant, m0_readdatavalid stays 0.
- Both masters read continuously (m0 at 0x001, m1 at 0x002) for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each master's waitrequest low every other cycle; no lost or duplicated readdatavalid.
- m1 read 0xC00 (3072) -> waitrequest=0, mem_chipselect=0, err_addr pulses 1 cycle, next cycle m1_readdata=ERR_RDATA and readdatavalid=1.
- Assert reset_n low one cycle after an m0 read is accepted -> no m0_readdatavalid; waitrequests=1 immediately (async); after release, clear restarts at address 0.
- CLEAR_ON_RESET=0: first cycle after reset release, simultaneous m0/m1 writes -> m0 granted first, m1 next cycle; busy=0 from the first cycle.
